set_assoc_cache_ctrl: RTL and testbench
=======================================

// Module: set_assoc_cache_ctrl
// PURPOSE
//   Parametrised N-way set-associative, write-back / write-allocate cache controller with true-LRU replacement.
//   Sits between a CPU load/store port (valid/ready request, one-cycle response pulse) and a word-serial backing-memory port.
//   Adds dirty-line writeback, explicit memory handshake and hit/miss counters over the fixed 4-way write-allocate generation.
// PARAMETERS
//   ADDR_W     32  byte address width
//   DATA_W     32  word width; power of 2, >=8
//   WAYS        4  associativity; power of 2, >=2
//   SETS       16  number of sets; power of 2, >=2
//   LINE_WORDS  4  words per line; power of 2, >=2
//   CNT_W      32  statistics counter width
// PORTS
//   clk        in   1           clock, rising edge
//   rst        in   1           asynchronous, active-high reset
//   req_valid  in   1           CPU request present
//   req_ready  out  1           controller can accept a request (IDLE)
//   req_rw     in   1           0 = read, 1 = write
//   req_addr   in   ADDR_W      byte address, word aligned (low bits ignored)
//   req_wdata  in   DATA_W      write data
//   resp_valid out  1           one-cycle response pulse
//   resp_rdata out  DATA_W      read: word read; write: word written
//   resp_hit   out  1           1 = access hit, 0 = serviced via miss
//   mem_req    out  1           memory transfer request, held until mem_ack
//   mem_we     out  1           1 = writeback word, 0 = fill word
//   mem_addr   out  ADDR_W      word-aligned memory address
//   mem_wdata  out  DATA_W      writeback data
//   mem_ack    in   1           memory completes the current word (fill: mem_rdata valid)
//   mem_rdata  in   DATA_W      fill data
//   hit_cnt    out  CNT_W       saturating hit count
//   miss_cnt   out  CNT_W       saturating miss count
// BEHAVIOUR
//   Address split, LSB first: byte offset log2(DATA_W/8), word offset log2(LINE_WORDS), index log2(SETS), tag = remainder.
//   Reset (async, rst=1): state IDLE; all valid, dirty and counters cleared; LRU age[w]=w in every set.
//     Outputs held at 0 while rst=1, including req_ready.
//     Tag/data arrays are not reset.
//     Reset mid-transfer drops mem_req immediately; the abandoned line stays invalid.
//   FSM states: IDLE, LOOKUP, EVICT, ALLOCATE, RESPOND.
//   IDLE
//     req_ready=1; accept on req_valid&&req_ready at posedge; latch rw/addr/wdata; -> LOOKUP.
//   LOOKUP
//     Compare tag against all valid ways of the indexed set.
//     Hit: read or write the word (write sets dirty); hit_cnt++; -> RESPOND with resp_hit=1.
//     Miss: miss_cnt++; choose victim = lowest-index invalid way, else way with age==WAYS-1.
//       Victim valid&&dirty -> EVICT, else -> ALLOCATE.
//   EVICT
//     LINE_WORDS writes, word 0 first: mem_we=1; mem_addr={victim tag,index,word,0}; mem_wdata=victim word.
//     Then -> ALLOCATE.
//   ALLOCATE
//     LINE_WORDS reads, word 0 first: mem_we=0; mem_addr={req tag,index,word,0}; capture mem_rdata on ack.
//     Then tag written, valid=1, dirty=0; a write is merged (dirty=1); -> RESPOND with resp_hit=0.
//   Memory handshake
//     mem_req/mem_we/mem_addr/mem_wdata stable while mem_req=1 and mem_ack=0.
//     One word per acked cycle; mem_req may stay high back-to-back; mem_ack with mem_req=0 is ignored.
//   RESPOND
//     resp_valid=1 for exactly one cycle; -> IDLE.
//     resp_rdata/resp_hit hold their values until the next response.
//   Latency
//     Hit: resp_valid in the 2nd cycle after the accept edge.
//     Miss: adds one cycle per acked word.
//   LRU
//     On every hit or fill of way w: ways with age < age[w] increment; age[w]=0.
//     Ages per set stay a permutation of 0..WAYS-1.
//   Busy: req_valid outside IDLE is ignored (req_ready=0); no queueing.
//   Counters saturate at all-ones and do not wrap.
// TESTING  (WAYS=4 SETS=16 LINE_WORDS=4; mem model returns addr as data; set 0 tags via 0x800000x00)
//   1 Cold write 0x80000000=0x12345678.
//     -> no EVICT; 4 fills at 0x80000000..0C; resp_hit=0; miss_cnt=1.
//   2 Read 0x80000000, then write 0x80000004=0xAABBCCDD, then read 0x80000004.
//     -> all resp_hit=1; rdata 0x12345678 / 0xAABBCCDD; resp_valid 2 cycles after accept; mem_req never 1; hit_cnt=3.
//   3 Write 0x80000100/200/300, then 0x80000400=0xDEAD0004.
//     -> first three: fills only.
//     -> last: writeback of 0x80000000..0C with data 0x12345678, 0xAABBCCDD, 0x80000008, 0x8000000C, then 4 fills.
//   4 Read 0x80000000 after step 3.
//     -> miss; clean LRU victim (0x80000100) with no writeback; rdata 0x12345678 (refetched).
//   5 mem_ack delayed 3 cycles per word during 3.
//     -> mem_req/mem_addr/mem_wdata stable across stall; req_valid pulses ignored, req_ready=0.
//   6 rst pulsed during ALLOCATE.
//     -> mem_req=0 same cycle; counters 0; req_ready=1 first cycle after release; read 0x80000000 misses.

Source files
------------

// File: rtl/set_assoc_cache_ctrl.sv
// ---------------------------------------------------------------------------
// set_assoc_cache_ctrl
//   N-way set-associative, write-back / write-allocate cache controller with
//   true-LRU replacement, dirty-line writeback and saturating hit/miss
//   statistics. Sits between a CPU load/store port and a word-serial backing
//   memory port.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   req_valid/req_ready           CPU request handshake (accepted in IDLE)
//   req_rw/req_addr/req_wdata     0 = read, 1 = write; byte address; write data
//   resp_valid                    one-cycle response pulse
//   resp_rdata/resp_hit           word read (or written) / hit flag, held
//                                 until the next response
//   mem_req/mem_we/mem_addr/
//   mem_wdata                     one word transfer to backing memory
//   mem_ack/mem_rdata             memory completes the word / fill data
//   hit_cnt/miss_cnt              saturating statistics counters
//   dbg_state                     current FSM state (state_t encoding)
//
// Handshake rules
//   CPU side : a request transfers on a rising edge where req_valid and
//              req_ready are both 1. req_ready is 1 only in IDLE; requests
//              presented while busy are ignored, never queued.
//   Mem side : mem_req, mem_we, mem_addr and mem_wdata are held stable while
//              mem_req=1 and mem_ack=0. Each rising edge with mem_req=1 and
//              mem_ack=1 completes one word; mem_req may stay high across
//              consecutive words. mem_ack while mem_req=0 is ignored.
// ---------------------------------------------------------------------------
module set_assoc_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [2:0]        dbg_state
);

    localparam int BO_W  = $clog2(DATA_W / 8);
    localparam int WO_W  = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - BO_W - WO_W - IDX_W;
    localparam logic [WO_W-1:0]  LAST_WORD = WO_W'(LINE_WORDS - 1);
    localparam logic [WAY_W-1:0] OLDEST    = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_EVICT    = 3'd2,
        S_ALLOCATE = 3'd3,
        S_RESPOND  = 3'd4
    } state_t;

    // Storage: tag/data arrays are deliberately left unreset.
    logic [TAG_W-1:0]  r_tag  [SETS][WAYS];
    logic [DATA_W-1:0] r_data [SETS][WAYS][LINE_WORDS];
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [WAY_W-1:0]  r_age  [SETS][WAYS];

    // FSM and latched request
    state_t            r_state;
    logic              r_req_ready;
    logic              r_rw;
    logic [TAG_W-1:0]  r_req_tag;
    logic [IDX_W-1:0]  r_req_idx;
    logic [WO_W-1:0]   r_req_word;
    logic [DATA_W-1:0] r_wdata;
    logic [WO_W-1:0]   r_cnt;
    logic [WAY_W-1:0]  r_victim;
    logic [DATA_W-1:0] r_fill_word;

    // Registered outputs
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_hit;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_found_inv;
    logic [WAY_W-1:0]  w_victim;
    logic              w_word_done;
    logic              w_fill_wr;
    logic              w_hit_wr;
    logic              w_lru_en;
    logic [WAY_W-1:0]  w_lru_way;
    logic [DATA_W-1:0] w_fill_data;

    // The byte-offset bits of the address carry no information for a
    // word-aligned access.
    generate
        if (BO_W > 0) begin : g_bo
            logic w_unused_bo;
            assign w_unused_bo = ^req_addr[BO_W-1:0];
        end
    endgenerate

    function automatic logic [ADDR_W-1:0] mk_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [WO_W-1:0]  wd);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[ADDR_W-1 -: TAG_W]    = t;
        a[BO_W + WO_W +: IDX_W] = i;
        a[BO_W +: WO_W]         = wd;
        return a;
    endfunction

    // Tag compare across all valid ways of the indexed set.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && r_valid[r_req_idx][w] && (r_tag[r_req_idx][w] == r_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the least recently used.
    always_comb begin
        w_found_inv = 1'b0;
        w_victim    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found_inv && !r_valid[r_req_idx][w]) begin
                w_found_inv = 1'b1;
                w_victim    = WAY_W'(w);
            end
        end
        if (!w_found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[r_req_idx][w] == OLDEST) begin
                    w_victim = WAY_W'(w);
                end
            end
        end
    end

    assign w_word_done = r_mem_req && mem_ack;
    assign w_fill_wr   = (r_state == S_ALLOCATE) && w_word_done;
    assign w_hit_wr    = (r_state == S_LOOKUP) && w_hit && r_rw;
    // A write miss merges its word into the incoming line as it arrives.
    assign w_fill_data = (r_rw && (r_cnt == r_req_word)) ? r_wdata : mem_rdata;
    assign w_lru_en    = ((r_state == S_LOOKUP) && w_hit) ||
                         (w_fill_wr && (r_cnt == LAST_WORD));
    assign w_lru_way   = (r_state == S_LOOKUP) ? w_hit_way : r_victim;

    // Tag/data array writes (no reset).
    always_ff @(posedge clk) begin
        if (w_hit_wr) begin
            r_data[r_req_idx][w_hit_way][r_req_word] <= r_wdata;
        end
        if (w_fill_wr) begin
            r_data[r_req_idx][r_victim][r_cnt] <= w_fill_data;
            if (r_cnt == LAST_WORD) begin
                r_tag[r_req_idx][r_victim] <= r_req_tag;
            end
        end
    end

    // Control FSM, metadata and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_rw         <= 1'b0;
            r_req_tag    <= '0;
            r_req_idx    <= '0;
            r_req_word   <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_victim     <= '0;
            r_fill_word  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_hit   <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            // True LRU: everything younger than the touched way ages by one.
            if (w_lru_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == w_lru_way) begin
                        r_age[r_req_idx][w] <= '0;
                    end else if (r_age[r_req_idx][w] < r_age[r_req_idx][w_lru_way]) begin
                        r_age[r_req_idx][w] <= r_age[r_req_idx][w] + 1'b1;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_rw        <= req_rw;
                        r_req_tag   <= req_addr[ADDR_W-1 -: TAG_W];
                        r_req_idx   <= req_addr[BO_W + WO_W +: IDX_W];
                        r_req_word  <= req_addr[BO_W +: WO_W];
                        r_wdata     <= req_wdata;
                        r_state     <= S_LOOKUP;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                        if (r_rw) r_dirty[r_req_idx][w_hit_way] <= 1'b1;
                        r_resp_rdata <= r_rw ? r_wdata : r_data[r_req_idx][w_hit_way][r_req_word];
                        r_resp_hit   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESPOND;
                    end else begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                        r_victim  <= w_victim;
                        r_cnt     <= '0;
                        r_mem_req <= 1'b1;
                        // The victim is invalid from here on, so an abandoned
                        // transfer never leaves a half-filled valid line.
                        r_valid[r_req_idx][w_victim] <= 1'b0;
                        r_dirty[r_req_idx][w_victim] <= 1'b0;
                        if (r_valid[r_req_idx][w_victim] && r_dirty[r_req_idx][w_victim]) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= mk_addr(r_tag[r_req_idx][w_victim], r_req_idx, '0);
                            r_mem_wdata <= r_data[r_req_idx][w_victim][0];
                            r_state     <= S_EVICT;
                        end else begin
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= mk_addr(r_req_tag, r_req_idx, '0);
                            r_state    <= S_ALLOCATE;
                        end
                    end
                end

                S_EVICT: begin
                    if (w_word_done) begin
                        if (r_cnt == LAST_WORD) begin
                            // mem_req stays high straight into the fill.
                            r_cnt      <= '0;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= mk_addr(r_req_tag, r_req_idx, '0);
                            r_state    <= S_ALLOCATE;
                        end else begin
                            r_cnt       <= r_cnt + 1'b1;
                            r_mem_addr  <= mk_addr(r_tag[r_req_idx][r_victim], r_req_idx, r_cnt + 1'b1);
                            r_mem_wdata <= r_data[r_req_idx][r_victim][r_cnt + 1'b1];
                        end
                    end
                end

                S_ALLOCATE: begin
                    if (w_word_done) begin
                        if (r_cnt == r_req_word) r_fill_word <= w_fill_data;
                        if (r_cnt == LAST_WORD) begin
                            r_mem_req    <= 1'b0;
                            r_valid[r_req_idx][r_victim] <= 1'b1;
                            r_dirty[r_req_idx][r_victim] <= r_rw;
                            r_resp_rdata <= (r_cnt == r_req_word) ? w_fill_data : r_fill_word;
                            r_resp_hit   <= 1'b0;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESPOND;
                        end else begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_mem_addr <= mk_addr(r_req_tag, r_req_idx, r_cnt + 1'b1);
                        end
                    end
                end

                S_RESPOND: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_hit   = r_resp_hit;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_set_assoc_cache_ctrl
//   Directed bench for set_assoc_cache_ctrl (4 ways, 16 sets, 4-word lines).
//   The memory model answers a fill with the last word written back to that
//   address, or with the address itself if never written. Every memory word
//   transfer is logged and compared against an expected queue.
// ---------------------------------------------------------------------------
module tb_set_assoc_cache_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    always #5 clk = ~clk;

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_hit;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    logic [2:0]        dbg_state;

    set_assoc_cache_ctrl #(
        .ADDR_W(32), .DATA_W(32), .WAYS(4), .SETS(16), .LINE_WORDS(4), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model + scoreboard ----------------
    // Entry: {we, addr, wdata}; fills log wdata as 0.
    logic [64:0]       exp_q[$];
    logic [64:0]       log_q[$];
    logic [DATA_W-1:0] mem_store [logic [ADDR_W-1:0]];
    int                stall = 0;
    int                wait_cnt = 0;
    int                memreq_cycles = 0;
    logic [64:0]       snap;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        snap      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) memreq_cycles++;
            if (mem_ack || rst) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt == 0) snap = {mem_we, mem_addr, mem_wdata};
                else check("stall_stable", {31'd0, mem_we, mem_addr, mem_wdata}, {31'd0, snap});
                if (wait_cnt < stall) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    mem_ack  = 1'b1;
                    if (mem_we) begin
                        mem_store[mem_addr] = mem_wdata;
                        log_q.push_back({1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : mem_addr;
                        log_q.push_back({1'b0, mem_addr, 32'h0});
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic exp_fill(input logic [ADDR_W-1:0] base);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, base + ADDR_W'(4 * i), 32'h0});
    endtask

    task automatic exp_wb(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] d0,
                          input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                          input logic [DATA_W-1:0] d3);
        exp_q.push_back({1'b1, base,         d0});
        exp_q.push_back({1'b1, base + 32'h4, d1});
        exp_q.push_back({1'b1, base + 32'h8, d2});
        exp_q.push_back({1'b1, base + 32'hC, d3});
    endtask

    task automatic check_mem(input string tag);
        logic [64:0] e;
        logic [64:0] g;
        check({tag, "_words"}, 96'(log_q.size()), 96'(exp_q.size()));
        while (exp_q.size() > 0 && log_q.size() > 0) begin
            e = exp_q.pop_front();
            g = log_q.pop_front();
            check({tag, "_we_addr"}, 96'(g[64:32]), 96'(e[64:32]));
            check({tag, "_wdata"},   96'(g[31:0]),  96'(e[31:0]));
        end
        exp_q.delete();
        log_q.delete();
    endtask

    // ---------------- driver ----------------
    // Issues one request, waits (bounded) for the response pulse. lat counts
    // cycles after the accept edge: 1 = cycle right after it.
    task automatic do_req(input logic rw, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input bit noise,
                          output logic [DATA_W-1:0] rdata, output logic hit, output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 96'(guard < 100), 96'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 400) begin
            if (noise) begin
                check("busy_ready", 96'(req_ready), 96'd0);
                req_valid = 1'($urandom_range(0, 1));
                req_rw    = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        req_valid = 1'b0;
        check("resp_timeout", 96'(lat < 400), 96'd1);
        rdata = resp_rdata;
        hit   = resp_hit;
        @(posedge clk);
        #1;
        check("resp_pulse", 96'(resp_valid), 96'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] rd;
    logic              hit;
    int                lat;
    int                base_req;
    int                guard;

    initial begin
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  96'(req_ready),  96'd0);
        check("rst_resp",   96'(resp_valid), 96'd0);
        check("rst_memreq", 96'(mem_req),    96'd0);
        check("rst_hits",   96'(hit_cnt),    96'd0);
        check("rst_miss",   96'(miss_cnt),   96'd0);
        check("rst_state",  96'(dbg_state),  96'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 96'(req_ready), 96'd1);

        // cold write miss: fills only
        do_req(1'b1, 32'h8000_0000, 32'h1234_5678, 1'b0, rd, hit, lat);
        check("s1_hit",   96'(hit), 96'd0);
        check("s1_rdata", 96'(rd),  96'h1234_5678);
        check("s1_miss",  96'(miss_cnt), 96'd1);
        check("s1_hits",  96'(hit_cnt),  96'd0);
        exp_fill(32'h8000_0000);
        check_mem("s1");

        // hits: no memory traffic, 2-cycle latency
        base_req = memreq_cycles;
        do_req(1'b0, 32'h8000_0000, 32'h0, 1'b0, rd, hit, lat);
        check("s2a_hit", 96'(hit), 96'd1);
        check("s2a_rdata", 96'(rd), 96'h1234_5678);
        check("s2a_lat", 96'(lat), 96'd2);
        do_req(1'b1, 32'h8000_0004, 32'hAABB_CCDD, 1'b0, rd, hit, lat);
        check("s2b_hit", 96'(hit), 96'd1);
        check("s2b_rdata", 96'(rd), 96'hAABB_CCDD);
        check("s2b_lat", 96'(lat), 96'd2);
        do_req(1'b0, 32'h8000_0004, 32'h0, 1'b0, rd, hit, lat);
        check("s2c_hit", 96'(hit), 96'd1);
        check("s2c_rdata", 96'(rd), 96'hAABB_CCDD);
        check("s2c_lat", 96'(lat), 96'd2);
        check("s2_no_memreq", 96'(memreq_cycles - base_req), 96'd0);
        check("s2_hits", 96'(hit_cnt), 96'd3);
        check("s2_miss", 96'(miss_cnt), 96'd1);
        repeat (2) @(posedge clk);
        #1;
        check("s2_hold_rdata", 96'(resp_rdata), 96'hAABB_CCDD);
        check("s2_hold_hit",   96'(resp_hit),   96'd1);

        // fill remaining ways of set 0 with stalled memory and busy noise
        stall = 3;
        do_req(1'b0, 32'h8000_0100, 32'h0, 1'b1, rd, hit, lat);
        check("s3a_hit", 96'(hit), 96'd0);
        check("s3a_rdata", 96'(rd), 96'h8000_0100);
        exp_fill(32'h8000_0100);
        check_mem("s3a");
        do_req(1'b0, 32'h8000_0200, 32'h0, 1'b1, rd, hit, lat);
        check("s3b_rdata", 96'(rd), 96'h8000_0200);
        exp_fill(32'h8000_0200);
        check_mem("s3b");
        do_req(1'b0, 32'h8000_0300, 32'h0, 1'b1, rd, hit, lat);
        check("s3c_rdata", 96'(rd), 96'h8000_0300);
        exp_fill(32'h8000_0300);
        check_mem("s3c");
        // LRU way 0 is dirty: writeback then fill
        do_req(1'b1, 32'h8000_0400, 32'hDEAD_0004, 1'b1, rd, hit, lat);
        check("s3d_hit", 96'(hit), 96'd0);
        check("s3d_rdata", 96'(rd), 96'hDEAD_0004);
        exp_wb(32'h8000_0000, 32'h1234_5678, 32'hAABB_CCDD, 32'h8000_0008, 32'h8000_000C);
        exp_fill(32'h8000_0400);
        check_mem("s3d");
        check("s3_miss", 96'(miss_cnt), 96'd5);
        check("s3_hits", 96'(hit_cnt), 96'd3);
        stall = 0;

        // refetch evicted line; LRU victim is the clean 0x100 line
        do_req(1'b0, 32'h8000_0000, 32'h0, 1'b0, rd, hit, lat);
        check("s4_hit", 96'(hit), 96'd0);
        check("s4_rdata", 96'(rd), 96'h1234_5678);
        exp_fill(32'h8000_0000);
        check_mem("s4");
        check("s4_miss", 96'(miss_cnt), 96'd6);
        do_req(1'b0, 32'h8000_0004, 32'h0, 1'b0, rd, hit, lat);
        check("s4b_hit", 96'(hit), 96'd1);
        check("s4b_rdata", 96'(rd), 96'hAABB_CCDD);
        do_req(1'b0, 32'h8000_0400, 32'h0, 1'b0, rd, hit, lat);
        check("s4c_hit", 96'(hit), 96'd1);
        check("s4c_rdata", 96'(rd), 96'hDEAD_0004);
        check("s4_hits", 96'(hit_cnt), 96'd5);

        // reset during ALLOCATE
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 32'h8000_0500;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        guard = 0;
        while (log_q.size() < 1 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("s6_fill_started", 96'(guard < 50), 96'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("s6_memreq", 96'(mem_req), 96'd0);
        check("s6_ready", 96'(req_ready), 96'd0);
        check("s6_hits", 96'(hit_cnt), 96'd0);
        check("s6_miss", 96'(miss_cnt), 96'd0);
        check("s6_state", 96'(dbg_state), 96'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("s6_ready_release", 96'(req_ready), 96'd1);
        log_q.delete();
        exp_q.delete();
        do_req(1'b0, 32'h8000_0000, 32'h0, 1'b0, rd, hit, lat);
        check("s6_post_hit", 96'(hit), 96'd0);
        check("s6_post_rdata", 96'(rd), 96'h1234_5678);
        exp_fill(32'h8000_0000);
        check_mem("s6");
        check("s6_post_miss", 96'(miss_cnt), 96'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // overall time limit
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
